// File: rtl/da_pkg.sv
// Types and constants shared by the DA subfilter control path and subfilter instances.
package da_pkg;

    localparam int DA_WORD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        RUN,
        WAIT
    } da_ctrl_state_e;

endpackage

// File: rtl/da_out_slot.sv
// One-entry valid/ready result register: loaded once per frame, cleared when drained.
module da_out_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data
);

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (m_valid_q && drain) begin
            m_valid_d = 1'b0;
        end
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    // The controller only starts a frame once the slot is empty or draining.
    a_no_overwrite: assert property (@(posedge clk) disable iff (!rst) load |-> !m_valid_q);

endmodule

// File: rtl/da_frame_ctrl.sv
// Initiator for a bit-serial DA subfilter: loads one sample, steps WORD_WIDTH bits,
// then captures the subfilter result into a valid/ready output slot.
module da_frame_ctrl
    import da_pkg::*;
#(
    parameter int WORD_WIDTH = DA_WORD_WIDTH,
    parameter int LOAD_GAP   = 1,
    parameter int Y_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    output logic                  sf_x_we,
    output logic [WORD_WIDTH-1:0] sf_x,
    output logic                  sf_en,
    output logic                  sf_ts,
    input  logic [WORD_WIDTH-1:0] sf_y,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  busy
);

    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam logic [BW-1:0] BIT_INIT  = BW'(WORD_WIDTH - 1);
    localparam logic [3:0]    GAP_INIT  = 4'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);
    localparam logic [1:0]    WAIT_INIT = 2'(Y_LAT - 1);

    da_ctrl_state_e          state_q, state_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]              wait_cnt_q, wait_cnt_d;
    logic [WORD_WIDTH-1:0]   sf_x_q, sf_x_d;
    logic                    sf_x_we_q, sf_x_we_d;
    logic                    sf_en_q, sf_en_d;
    logic                    sf_ts_q, sf_ts_d;
    logic                    busy_q, busy_d;
    logic                    idle_q, idle_d;
    logic                    slot_load;
    logic                    accept;

    // idle_q stays low during reset so s_ready is deasserted until the first clock after release.
    assign s_ready = idle_q && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        sf_x_d     = sf_x_q;
        slot_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sf_x_d  = s_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (LOAD_GAP == 0) begin
                    state_d   = RUN;
                    bit_cnt_d = BIT_INIT;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_INIT;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d   = RUN;
                    bit_cnt_d = BIT_INIT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            RUN: begin
                if (bit_cnt_q == '0) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_INIT;
                end else begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end
            end
            WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d   = IDLE;
                    slot_load = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they line up with the state they belong to.
        sf_x_we_d = (state_d == LOAD);
        sf_en_d   = (state_d == RUN);
        sf_ts_d   = (state_d == RUN) && (bit_cnt_d == '0);
        busy_d    = (state_d != IDLE);
        idle_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            sf_x_q     <= '0;
            sf_x_we_q  <= 1'b0;
            sf_en_q    <= 1'b0;
            sf_ts_q    <= 1'b0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sf_x_q     <= sf_x_d;
            sf_x_we_q  <= sf_x_we_d;
            sf_en_q    <= sf_en_d;
            sf_ts_q    <= sf_ts_d;
            busy_q     <= busy_d;
            idle_q     <= idle_d;
        end
    end

    assign sf_x    = sf_x_q;
    assign sf_x_we = sf_x_we_q;
    assign sf_en   = sf_en_q;
    assign sf_ts   = sf_ts_q;
    assign busy    = busy_q;

    da_out_slot #(
        .WIDTH(WORD_WIDTH)
    ) u_out_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (slot_load),
        .load_data(sf_y),
        .drain    (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data)
    );

endmodule

// File: tb/tb_da_frame_ctrl.sv
// Directed and scoreboarded checks of da_frame_ctrl with a bit-serial multiply-by-7 subfilter.
module tb_da_frame_ctrl;

    localparam int W = 16;
    localparam logic [W-1:0] COEF = 16'h0007;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         s_valid, s_ready, sf_x_we, sf_en, sf_ts, m_valid, m_ready, busy;
    logic [W-1:0] s_data, sf_x, sf_y, m_data;

    logic         p_s_valid, p_s_ready, p_sf_x_we, p_sf_en, p_sf_ts, p_m_valid, p_m_ready, p_busy;
    logic [W-1:0] p_s_data, p_sf_x, p_sf_y, p_m_data;

    int errors = 0;
    int checks = 0;

    da_frame_ctrl dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .sf_x_we(sf_x_we), .sf_x(sf_x), .sf_en(sf_en), .sf_ts(sf_ts), .sf_y(sf_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    da_frame_ctrl #(.WORD_WIDTH(16), .LOAD_GAP(0), .Y_LAT(3)) dut_p (
        .clk(clk), .rst(rst), .s_valid(p_s_valid), .s_ready(p_s_ready), .s_data(p_s_data),
        .sf_x_we(p_sf_x_we), .sf_x(p_sf_x), .sf_en(p_sf_en), .sf_ts(p_sf_ts), .sf_y(p_sf_y),
        .m_valid(p_m_valid), .m_ready(p_m_ready), .m_data(p_m_data), .busy(p_busy)
    );

    // Bit-serial subfilter: LSB first, sign step subtracts; result is x*COEF mod 2^16.
    logic [W-1:0] mdl_sh, mdl_w, mdl_acc;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_sh  <= '0;
            mdl_w   <= '0;
            mdl_acc <= '0;
        end else if (sf_x_we) begin
            mdl_sh  <= sf_x;
            mdl_w   <= COEF;
            mdl_acc <= '0;
        end else if (sf_en) begin
            mdl_acc <= sf_ts ? mdl_acc - (mdl_sh[0] ? mdl_w : 16'h0)
                             : mdl_acc + (mdl_sh[0] ? mdl_w : 16'h0);
            mdl_sh  <= mdl_sh >> 1;
            mdl_w   <= mdl_w << 1;
        end
    end
    assign sf_y   = mdl_acc;
    assign p_sf_y = 16'hA5C3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_m_valid(input string name);
        int n = 0;
        while (!m_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: m_valid=%b after %0d cycles, want 1", name, m_valid, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        p_s_valid = 1'b0; p_s_data = '0; p_m_ready = 1'b1;
        tick();
        checks++;
        if ({s_ready, sf_x_we, sf_en, sf_ts, m_valid, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {s_ready, sf_x_we, sf_en, sf_ts, m_valid, busy});
        end
        checks++;
        if (sf_x !== 16'h0 || m_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: sf_x=%h m_data=%h want 0000 0000", sf_x, m_data);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b busy=%b want 1 0", s_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp4;
        s_data = 16'h4000; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: s_ready=%b want 1", s_ready);
        end
        tick();
        s_valid = 1'b0; s_data = 16'hFFFF;
        for (int k = 1; k <= 22; k++) begin
            exp4 = {(k == 1), (k >= 3 && k <= 18), (k == 18), (k == 20)};
            checks++;
            if ({sf_x_we, sf_en, sf_ts, m_valid} !== exp4) begin
                errors++;
                $display("FAIL single_strobes t+%0d: we/en/ts/mv=%b want %b",
                         k, {sf_x_we, sf_en, sf_ts, m_valid}, exp4);
            end
            if (k == 1) begin
                checks++;
                if (sf_x !== 16'h4000 || busy !== 1'b1 || s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL single_load: sf_x=%h busy=%b s_ready=%b want 4000 1 0",
                             sf_x, busy, s_ready);
                end
            end
            if (k == 20) begin
                checks++;
                if (m_data !== 16'hC000) begin
                    errors++;
                    $display("FAIL single_data: m_data=%h want c000", m_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] smp [3];
        logic [W-1:0] res [3];
        int acc_cyc [3];
        int en_cnt [3];
        int n_acc = 0;
        int n_res = 0;
        int cyc = 0;
        smp = '{16'h1234, 16'h8001, 16'h7FFF};
        res = '{16'h7F6C, 16'h8007, 16'h7FF9};
        en_cnt = '{0, 0, 0};
        acc_cyc = '{0, 0, 0};
        s_valid = 1'b1; s_data = smp[0]; m_ready = 1'b1;
        #1;
        while (n_res < 3 && cyc < 200) begin
            if (sf_en && n_acc > 0) en_cnt[n_acc-1]++;
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== res[n_res]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: m_data=%h want %h", n_res, m_data, res[n_res]);
                end
                n_res++;
            end
            if (s_valid && s_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
            cyc++;
            if (n_acc < 3) s_data = smp[n_acc];
            else s_valid = 1'b0;
        end
        checks++;
        if (n_res != 3 || n_acc != 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d want 3 3", n_acc, n_res);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (en_cnt[i] != 16) begin
                errors++;
                $display("FAIL b2b_en[%0d]: sf_en cycles=%0d want 16", i, en_cnt[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 20) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: %0d cycles want 20", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0101;
        tick();
        s_data = 16'h0202;
        wait_m_valid("bp_first");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({m_valid, s_ready, sf_x_we, busy} !== 4'b1000 || m_data !== 16'h0707) begin
                errors++;
                $display("FAIL bp_hold[%0d]: mv/rdy/we/busy=%b m_data=%h want 1000 0707",
                         i, {m_valid, s_ready, sf_x_we, busy}, m_data);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: s_ready=%b want 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if ({m_valid, sf_x_we} !== 2'b01 || sf_x !== 16'h0202) begin
            errors++;
            $display("FAIL bp_drain_accept: mv/we=%b sf_x=%h want 01 0202", {m_valid, sf_x_we}, sf_x);
        end
        wait_m_valid("bp_second");
        checks++;
        if (m_data !== 16'h0E0E) begin
            errors++;
            $display("FAIL bp_second_data: m_data=%h want 0e0e", m_data);
        end
        tick();
    endtask

    task automatic test_params();
        logic [3:0] exp4;
        p_s_data = 16'h1111; p_s_valid = 1'b1; p_m_ready = 1'b1;
        #1;
        checks++;
        if (p_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL param_ready: s_ready=%b want 1", p_s_ready);
        end
        tick();
        p_s_valid = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            exp4 = {(k == 1), (k >= 2 && k <= 17), (k == 17), (k == 21)};
            checks++;
            if ({p_sf_x_we, p_sf_en, p_sf_ts, p_m_valid} !== exp4) begin
                errors++;
                $display("FAIL param_strobes t+%0d: we/en/ts/mv=%b want %b",
                         k, {p_sf_x_we, p_sf_en, p_sf_ts, p_m_valid}, exp4);
            end
            if (k == 21) begin
                checks++;
                if (p_m_data !== 16'hA5C3) begin
                    errors++;
                    $display("FAIL param_data: m_data=%h want a5c3", p_m_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        int stray = 0;
        s_valid = 1'b1; s_data = 16'h5555; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        checks++;
        if (sf_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_running: sf_en=%b want 1", sf_en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_ready, sf_x_we, sf_en, sf_ts, m_valid, busy} !== 6'b0 ||
            sf_x !== 16'h0 || m_data !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_async: ctrl=%b sf_x=%h m_data=%h want 000000 0000 0000",
                     {s_ready, sf_x_we, sf_en, sf_ts, m_valid, busy}, sf_x, m_data);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({s_ready, busy, m_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_release: rdy/busy/mv=%b want 100", {s_ready, busy, m_valid});
        end
        for (int k = 0; k < 30; k++) begin
            if (m_valid || sf_en || sf_x_we) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: %0d active cycles want 0", stray);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q [$];
        logic [W-1:0] exp_y;
        int sent = 0;
        int recv = 0;
        int ts_cnt = 0;
        int cyc = 0;
        while (recv < 100 && cyc < 20000) begin
            s_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 4) != 0);
            #1;
            if (sf_ts) ts_cnt++;
            if (s_valid && s_ready) begin
                q.push_back(16'(s_data * COEF));
                sent++;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: m_data=%h with empty scoreboard", m_data);
                end else begin
                    exp_y = q.pop_front();
                    if (m_data !== exp_y) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: m_data=%h want %h", recv, m_data, exp_y);
                    end
                end
                recv++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++;
        if (recv != 100) begin
            errors++;
            $display("FAIL rand_count: results=%0d want 100", recv);
        end
        checks++;
        if (ts_cnt != sent) begin
            errors++;
            $display("FAIL rand_ts: sf_ts pulses=%0d want %0d", ts_cnt, sent);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_params();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
